button_conditioner: RTL

Parametrised multi-channel input conditioner between the raw board buttons and the game logic, generalising the current three unconditioned button inputs. Each channel is synchronised, debounced and edge-detected, with optional per-channel auto-repeat, so held left/right/rotate keys move pieces at a controlled rate. It runs in the `clk_25_175` domain, and its pulse outputs are single-cycle strobes consumed by `cellstorage`.

---
 rtl/input_pkg.sv | 20 ++
 rtl/button_channel.sv | 137 +++++++++++++
 rtl/button_conditioner.sv | 41 ++++
 3 files changed

// File: rtl/input_pkg.sv
// Shared types, helpers and 25.175 MHz timing defaults for the button input path.
package input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 251750;   // ~10 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 6293750;  // ~250 ms
  localparam int unsigned DEF_REPEAT_PERIOD   = 2517500;  // ~100 ms

  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-FF synchroniser, debouncer and auto-repeat FSM.
module button_channel
  import input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic enable,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_fire
);

  localparam int unsigned DB_W   = clog2_min1(DEBOUNCE_CYCLES);
  localparam int unsigned RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RC_W   = clog2_min1(RC_MAX);

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  rpt_state_e      state_q, state_d;
  logic [RC_W-1:0] rcnt_q, rcnt_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            fire_q, fire_d;
  logic            toggle, rise, fall;

  always_comb begin
    sync1_d  = btn_raw ^ ACTIVE_LOW;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    db_cnt_d = '0;
    toggle   = 1'b0;
    if (sync2_q != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        toggle   = 1'b1;
        stable_d = ~stable_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
    rise = toggle & ~stable_q;
    fall = toggle & stable_q;
  end

  // Strobes are computed from the same-cycle toggle so they align with btn_level.
  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    fire_d    = 1'b0;
    press_d   = rise & enable;
    release_d = fall & enable;
    case (state_q)
      IDLE: begin
        if (rise) begin
          fire_d  = 1'b1;
          rcnt_d  = '0;
          state_d = REPEAT_EN ? DELAY : IDLE;
        end
      end
      DELAY: begin
        if (fall) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == DELAY_LAST) begin
          fire_d  = 1'b1;
          rcnt_d  = '0;
          state_d = REPEAT;
        end else begin
          rcnt_d = rcnt_q + RC_W'(1);
        end
      end
      REPEAT: begin
        if (fall) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == PERIOD_LAST) begin
          fire_d = 1'b1;
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + RC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase
    if (!enable) begin
      state_d = IDLE;
      rcnt_d  = '0;
      fire_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      stable_q  <= 1'b0;
      db_cnt_q  <= '0;
      state_q   <= IDLE;
      rcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      fire_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      fire_q    <= fire_d;
    end
  end

  assign btn_level   = stable_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_fire    = fire_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: independent sync/debounce/auto-repeat per channel.
module button_conditioner
  import input_pkg::*;
#(
  parameter int unsigned          CHANNELS        = 3,
  parameter int unsigned          DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned          REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned          REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [CHANNELS-1:0]  REPEAT_EN       = {CHANNELS{1'b1}},
  parameter logic [CHANNELS-1:0]  ACTIVE_LOW      = {CHANNELS{1'b0}}
) (
  input  logic                clk_25_175,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_raw,
  input  logic                enable,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_fire
);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_EN[gi]),
      .ACTIVE_LOW      (ACTIVE_LOW[gi])
    ) u_ch (
      .clk         (clk_25_175),
      .reset       (reset),
      .btn_raw     (btn_raw[gi]),
      .enable      (enable),
      .btn_level   (btn_level[gi]),
      .btn_press   (btn_press[gi]),
      .btn_release (btn_release[gi]),
      .btn_fire    (btn_fire[gi])
    );
  end

endmodule
